// File: rtl/cpu_pkg.sv
// Shared SM83 CPU control encodings and the packed control word.
// Imported by the CPU top level, cpu_control_unit and cpu_decoder.
package cpu_pkg;

    typedef enum logic {
        PC_SAME,
        PC_INC
    } pc_next_e;

    typedef enum logic [2:0] {
        SEL_A,
        SEL_W,
        SEL_Z,
        SEL_REG8_SRC,
        SEL_REG8_DEST,
        SEL_HL,
        SEL_REG16_HI,
        SEL_REG16_LO
    } reg_sel_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_WRITE_ALU,
        OP_WRITE_MEM,
        OP_INC_HL,
        OP_DEC_HL
    } reg_op_e;

    typedef enum logic {
        ALU_COPY_A,
        ALU_INC_A
    } alu_op_e;

    typedef enum logic {
        ALU_A_REG1
    } alu_sel_a_e;

    typedef enum logic {
        ALU_B_REG2
    } alu_sel_b_e;

    typedef enum logic [1:0] {
        ADDR_PC,
        ADDR_HL,
        ADDR_REG
    } mem_addr_sel_e;

    typedef struct packed {
        pc_next_e      pc_next;
        logic          inst_load;
        reg_sel_e      reg_read1_sel;
        reg_sel_e      reg_read2_sel;
        reg_sel_e      reg_write_sel;
        reg_op_e       reg_op;
        alu_op_e       alu_op;
        alu_sel_a_e    alu_sel_a;
        alu_sel_b_e    alu_sel_b;
        logic          mem_enable;
        logic          mem_write;
        mem_addr_sel_e mem_addr_sel;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_DEFAULT = '{
        pc_next:       PC_SAME,
        inst_load:     1'b0,
        reg_read1_sel: SEL_A,
        reg_read2_sel: SEL_A,
        reg_write_sel: SEL_A,
        reg_op:        OP_NONE,
        alu_op:        ALU_COPY_A,
        alu_sel_a:     ALU_A_REG1,
        alu_sel_b:     ALU_B_REG2,
        mem_enable:    1'b0,
        mem_write:     1'b0,
        mem_addr_sel:  ADDR_PC
    };

endpackage

// File: rtl/cpu_decoder.sv
// Combinational microcode map from (opcode, step) to the control word.
// INC r decoding is present only when CPU_CONTROL_INC_EN is defined.
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [1:0] step,
    output ctrl_word_t ctrl
);

    logic [2:0] dst;
    logic [2:0] src;
    logic       last;

    assign dst = opcode[5:3];
    assign src = opcode[2:0];

    always_comb begin
        ctrl = CTRL_DEFAULT;
        last = 1'b1;

        if (opcode == 8'h36) begin
            case (step)
                2'd0: begin
                    ctrl.mem_enable    = 1'b1;
                    ctrl.mem_addr_sel  = ADDR_PC;
                    ctrl.pc_next       = PC_INC;
                    ctrl.reg_write_sel = SEL_Z;
                    ctrl.reg_op        = OP_WRITE_MEM;
                    last               = 1'b0;
                end
                2'd1: begin
                    ctrl.mem_enable    = 1'b1;
                    ctrl.mem_write     = 1'b1;
                    ctrl.mem_addr_sel  = ADDR_HL;
                    ctrl.reg_read1_sel = SEL_Z;
                    last               = 1'b0;
                end
                default: ;
            endcase
        end else if (opcode[7:6] == 2'b01 && opcode != 8'h76) begin
            if (src == 3'd6) begin
                if (step == 2'd0) begin
                    ctrl.mem_enable    = 1'b1;
                    ctrl.mem_addr_sel  = ADDR_HL;
                    ctrl.reg_write_sel = SEL_REG8_DEST;
                    ctrl.reg_op        = OP_WRITE_MEM;
                    last               = 1'b0;
                end
            end else if (dst == 3'd6) begin
                if (step == 2'd0) begin
                    ctrl.mem_enable    = 1'b1;
                    ctrl.mem_write     = 1'b1;
                    ctrl.mem_addr_sel  = ADDR_HL;
                    ctrl.reg_read1_sel = SEL_REG8_SRC;
                    last               = 1'b0;
                end
            end else begin
                ctrl.reg_read1_sel = SEL_REG8_SRC;
                ctrl.reg_write_sel = SEL_REG8_DEST;
                ctrl.reg_op        = OP_WRITE_ALU;
            end
        end else if (opcode[7:6] == 2'b00 && src == 3'd6 && dst != 3'd6) begin
            if (step == 2'd0) begin
                ctrl.mem_enable    = 1'b1;
                ctrl.mem_addr_sel  = ADDR_PC;
                ctrl.pc_next       = PC_INC;
                ctrl.reg_write_sel = SEL_REG8_DEST;
                ctrl.reg_op        = OP_WRITE_MEM;
                last               = 1'b0;
            end
        end else if (opcode == 8'h0A || opcode == 8'h1A) begin
            if (step == 2'd0) begin
                ctrl.mem_enable    = 1'b1;
                ctrl.mem_addr_sel  = ADDR_REG;
                ctrl.reg_read1_sel = SEL_REG16_HI;
                ctrl.reg_read2_sel = SEL_REG16_LO;
                ctrl.reg_write_sel = SEL_A;
                ctrl.reg_op        = OP_WRITE_MEM;
                last               = 1'b0;
            end
        end else if (opcode == 8'h22 || opcode == 8'h32) begin
            if (step == 2'd0) begin
                ctrl.mem_enable    = 1'b1;
                ctrl.mem_write     = 1'b1;
                ctrl.mem_addr_sel  = ADDR_HL;
                ctrl.reg_read1_sel = SEL_A;
                ctrl.reg_op        = opcode[4] ? OP_DEC_HL : OP_INC_HL;
                last               = 1'b0;
            end
`ifdef CPU_CONTROL_INC_EN
        end else if (opcode[7:6] == 2'b00 && src == 3'd4 && dst != 3'd6) begin
            ctrl.reg_read1_sel = SEL_REG8_DEST;
            ctrl.alu_op        = ALU_INC_A;
            ctrl.reg_write_sel = SEL_REG8_DEST;
            ctrl.reg_op        = OP_WRITE_ALU;
`endif
        end

        // Final step of every instruction overlaps the next opcode fetch.
        if (last) begin
            ctrl.mem_enable   = 1'b1;
            ctrl.mem_addr_sel = ADDR_PC;
            ctrl.pc_next      = PC_INC;
            ctrl.inst_load    = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// SM83 control unit: opcode/step registers, reset gating and decoder instance.
// Optional INC r support is enabled by defining CPU_CONTROL_INC_EN.
module cpu_control_unit
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    t_cycle,
    input  logic [7:0]    mem_data_in,
    output pc_next_e      pc_next,
    output logic          inst_load,
    output reg_sel_e      reg_read1_sel,
    output reg_sel_e      reg_read2_sel,
    output reg_sel_e      reg_write_sel,
    output reg_op_e       reg_op,
    output alu_op_e       alu_op,
    output alu_sel_a_e    alu_sel_a,
    output alu_sel_b_e    alu_sel_b,
    output logic          mem_enable,
    output logic          mem_write,
    output mem_addr_sel_e mem_addr_sel
);

    logic [7:0] opcode;
    logic [1:0] step;
    ctrl_word_t dec_word;
    ctrl_word_t out_word;

    cpu_decoder u_decoder (
        .opcode (opcode),
        .step   (step),
        .ctrl   (dec_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            opcode <= 8'h00;
            step   <= 2'd0;
        end else if (t_cycle == 2'd3) begin
            if (dec_word.inst_load) begin
                opcode <= mem_data_in;
                step   <= 2'd0;
            end else begin
                step <= step + 2'd1;
            end
        end
    end

    always_comb begin
        out_word = reset ? CTRL_DEFAULT : dec_word;
    end

    assign pc_next       = out_word.pc_next;
    assign inst_load     = out_word.inst_load;
    assign reg_read1_sel = out_word.reg_read1_sel;
    assign reg_read2_sel = out_word.reg_read2_sel;
    assign reg_write_sel = out_word.reg_write_sel;
    assign reg_op        = out_word.reg_op;
    assign alu_op        = out_word.alu_op;
    assign alu_sel_a     = out_word.alu_sel_a;
    assign alu_sel_b     = out_word.alu_sel_b;
    assign mem_enable    = out_word.mem_enable;
    assign mem_write     = out_word.mem_write;
    assign mem_addr_sel  = out_word.mem_addr_sel;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed-vector bench for cpu_control_unit; one expected control word per M-cycle.
// Expectation for opcode 0x04 follows CPU_CONTROL_INC_EN.
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] t_cycle = 2'd0;
    logic [7:0] mem_data_in = 8'h00;

    logic       pc_next;
    logic       inst_load;
    logic [2:0] reg_read1_sel;
    logic [2:0] reg_read2_sel;
    logic [2:0] reg_write_sel;
    logic [2:0] reg_op;
    logic       alu_op;
    logic       alu_sel_a;
    logic       alu_sel_b;
    logic       mem_enable;
    logic       mem_write;
    logic [1:0] mem_addr_sel;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [2:0] S_A = 3'd0, S_Z = 3'd2, S_SRC = 3'd3, S_DST = 3'd4,
                           S_HI = 3'd6, S_LO = 3'd7;
    localparam logic [2:0] R_NONE = 3'd0, R_ALU = 3'd1, R_MEM = 3'd2, R_INCHL = 3'd3,
                           R_DECHL = 3'd4;
    localparam logic [1:0] A_PC = 2'd0, A_HL = 2'd1, A_REG = 2'd2;

    cpu_control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .t_cycle       (t_cycle),
        .mem_data_in   (mem_data_in),
        .pc_next       (pc_next),
        .inst_load     (inst_load),
        .reg_read1_sel (reg_read1_sel),
        .reg_read2_sel (reg_read2_sel),
        .reg_write_sel (reg_write_sel),
        .reg_op        (reg_op),
        .alu_op        (alu_op),
        .alu_sel_a     (alu_sel_a),
        .alu_sel_b     (alu_sel_b),
        .mem_enable    (mem_enable),
        .mem_write     (mem_write),
        .mem_addr_sel  (mem_addr_sel)
    );

    always #5 clk = ~clk;

    // {pc_next, inst_load, rd1, rd2, wr, reg_op, alu_op, sel_a, sel_b, men, mwr, addr}
    function automatic logic [20:0] cw(input logic pc, input logic il, input logic [2:0] r1,
                                       input logic [2:0] r2, input logic [2:0] rw,
                                       input logic [2:0] rop, input logic alu,
                                       input logic me, input logic mw, input logic [1:0] as);
        return {pc, il, r1, r2, rw, rop, alu, 1'b0, 1'b0, me, mw, as};
    endfunction

    function automatic logic [20:0] observed();
        return {pc_next, inst_load, reg_read1_sel, reg_read2_sel, reg_write_sel, reg_op,
                alu_op, alu_sel_a, alu_sel_b, mem_enable, mem_write, mem_addr_sel};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%06h, want 0x%06h", tag, obs, exp);
        end
    endtask

    // One M-cycle: drive bus data and reset, check the word at T0 and again at T3.
    task automatic mcycle(input logic [7:0] data, input logic rst, input logic [20:0] exp,
                          input string tag);
        @(negedge clk);
        t_cycle     = 2'd0;
        mem_data_in = data;
        reset       = rst;
        #1 check(tag, {11'd0, observed()}, {11'd0, exp});
        for (int t = 1; t < 4; t++) begin
            @(negedge clk);
            t_cycle = t[1:0];
        end
        #1 check({tag, "@t3"}, {11'd0, observed()}, {11'd0, exp});
    endtask

    logic [20:0] w_def, w_fetch, w_inc;

    initial begin
        w_def   = cw(1'b0, 1'b0, S_A, S_A, S_A, R_NONE, 1'b0, 1'b0, 1'b0, A_PC);
        w_fetch = cw(1'b1, 1'b1, S_A, S_A, S_A, R_NONE, 1'b0, 1'b1, 1'b0, A_PC);
`ifdef CPU_CONTROL_INC_EN
        w_inc   = cw(1'b1, 1'b1, S_DST, S_A, S_DST, R_ALU, 1'b1, 1'b1, 1'b0, A_PC);
`else
        w_inc   = w_fetch;
`endif

        mcycle(8'h00, 1'b1, w_def, "reset");
        mcycle(8'h00, 1'b1, w_def, "reset2");
        mcycle(8'h78, 1'b0, w_fetch, "boot_fetch");
        mcycle(8'h3E, 1'b0, cw(1'b1, 1'b1, S_SRC, S_A, S_DST, R_ALU, 1'b0, 1'b1, 1'b0, A_PC),
               "ld_a_b");
        mcycle(8'hFF, 1'b0, cw(1'b1, 1'b0, S_A, S_A, S_DST, R_MEM, 1'b0, 1'b1, 1'b0, A_PC),
               "ld_a_n_m0");
        mcycle(8'h36, 1'b0, w_fetch, "ld_a_n_m1");
        mcycle(8'h5A, 1'b0, cw(1'b1, 1'b0, S_A, S_A, S_Z, R_MEM, 1'b0, 1'b1, 1'b0, A_PC),
               "ld_hl_n_m0");
        mcycle(8'h78, 1'b0, cw(1'b0, 1'b0, S_Z, S_A, S_A, R_NONE, 1'b0, 1'b1, 1'b1, A_HL),
               "ld_hl_n_m1");
        mcycle(8'h32, 1'b0, w_fetch, "ld_hl_n_m2");
        mcycle(8'h00, 1'b0, cw(1'b0, 1'b0, S_A, S_A, S_A, R_DECHL, 1'b0, 1'b1, 1'b1, A_HL),
               "ld_hld_a_m0");
        mcycle(8'h04, 1'b0, w_fetch, "ld_hld_a_m1");
        mcycle(8'h0A, 1'b0, w_inc, "inc_b");
        mcycle(8'h00, 1'b0, cw(1'b0, 1'b0, S_HI, S_LO, S_A, R_MEM, 1'b0, 1'b1, 1'b0, A_REG),
               "ld_a_bc_m0");
        mcycle(8'h70, 1'b0, w_fetch, "ld_a_bc_m1");
        mcycle(8'h00, 1'b0, cw(1'b0, 1'b0, S_SRC, S_A, S_A, R_NONE, 1'b0, 1'b1, 1'b1, A_HL),
               "ld_hl_b_m0");
        mcycle(8'h46, 1'b0, w_fetch, "ld_hl_b_m1");
        mcycle(8'h00, 1'b0, cw(1'b0, 1'b0, S_A, S_A, S_DST, R_MEM, 1'b0, 1'b1, 1'b0, A_HL),
               "ld_b_hl_m0");
        mcycle(8'h76, 1'b0, w_fetch, "ld_b_hl_m1");
        mcycle(8'h36, 1'b0, w_fetch, "halt_as_nop");
        mcycle(8'h11, 1'b0, cw(1'b1, 1'b0, S_A, S_A, S_Z, R_MEM, 1'b0, 1'b1, 1'b0, A_PC),
               "ld_hl_n_m0b");
        mcycle(8'hAA, 1'b1, w_def, "rst_mid_36");
        mcycle(8'h22, 1'b0, w_fetch, "post_rst_fetch");
        mcycle(8'h00, 1'b0, cw(1'b0, 1'b0, S_A, S_A, S_A, R_INCHL, 1'b0, 1'b1, 1'b1, A_HL),
               "ld_hli_a_m0");
        mcycle(8'h00, 1'b0, w_fetch, "ld_hli_a_m1");
        mcycle(8'h00, 1'b0, w_fetch, "nop_tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Microcoded control unit for the SM83 (Game Boy) CPU core. It tracks the current opcode and its M-cycle step, and drives every datapath control signal: PC update, register-file selects and write operation, ALU operation and operand selects, and bus address source, enable and write. It sits inside the CPU top level beside the register file, ALU and PC, and is paced by the top level's 2-bit T-cycle counter.

## Interface
Parameters: none.

Enum encodings are positional, in the order listed, starting at 0.

- clk  in  1  system clock (4 MHz nominal)
- reset  in  1  synchronous, active-high; clock clk
- t_cycle  in  2  T-cycle within the M-cycle (0..3, driven by the CPU top level)
- mem_data_in  in  8  bus read data, valid at t_cycle==3
- pc_next  out  1  pc_next_e: Same(0), Inc(1)
- inst_load  out  1  the current M-cycle fetches the next opcode
- reg_read1_sel, reg_read2_sel, reg_write_sel  out  3 each  reg_sel_e: A, W, Z, Reg8Src[2:0], Reg8Dest[5:3], HL, Reg16Hi[5:4], Reg16Lo[5:4]
- reg_op  out  3  reg_op_e: None, WriteAlu, WriteMem, IncHl, DecHl
- alu_op  out  1  alu_op_e: CopyA, IncA
- alu_sel_a, alu_sel_b  out  1 each  Reg1 / Reg2 (only value)
- mem_enable, mem_write  out  1 each  bus access enable / write strobe
- mem_addr_sel  out  2  mem_addr_sel_e: Pc, Hl, Reg

## Operation
- State: opcode register (8 bits, reset 0x00) and step counter (2 bits, reset 0).
- Default control word: pc_next=Same, inst_load=0, all selects=A, reg_op=None, alu_op=CopyA, alu_sel=Reg1/Reg2, mem_enable=0, mem_write=0, mem_addr_sel=Pc.
- Fetch word: mem_enable=1, mem_addr_sel=Pc, pc_next=Inc, inst_load=1. It is ORed into the last step of every instruction.
- Microcode, by step (each M step ends with the Fetch word):
  - NOP 0x00: M0 Fetch.
  - LD r,r' (01dddsss, d≠6, s≠6): M0 read1=Reg8Src, CopyA, write=Reg8Dest, WriteAlu, plus Fetch.
  - LD r,n (00ddd110, d≠6): M0 bus read at Pc, pc Inc, write=Reg8Dest, WriteMem. M1 Fetch.
  - LD (HL),n 0x36: M0 read Pc, pc Inc, write=Z, WriteMem. M1 addr Hl, mem_write, read1=Z. M2 Fetch.
  - LD r,(HL) (01ddd110, d≠6): M0 addr Hl, write=Reg8Dest, WriteMem. M1 Fetch.
  - LD (HL),r (01110sss, s≠6): M0 addr Hl, mem_write, read1=Reg8Src. M1 Fetch.
  - LD A,(BC)/(DE) 0x0A/0x1A: M0 addr Reg, read1=Reg16Hi, read2=Reg16Lo, write=A, WriteMem. M1 Fetch.
  - LD (HL+),A 0x22 and LD (HL-),A 0x32: M0 addr Hl, mem_write, read1=A, reg_op IncHl / DecHl. M1 Fetch.
  - INC r (00ddd100, d≠6): M0 read1=Reg8Dest, IncA, write=Reg8Dest, WriteAlu, plus Fetch. Present only when the configuration macro is defined.
  - Every other opcode (including HALT 0x76) executes as NOP.
- Every M-cycle performs at most one bus access.
- While reset is high, all outputs hold the default word.

## Timing
- Outputs are combinational from the opcode and step registers only. They are stable across all four T-cycles of an M-cycle.
- The datapath samples control at t_cycle==3.
- State updates on posedge clk when t_cycle==3 and reset is low:
  - If inst_load=1: opcode ← mem_data_in and step ← 0.
  - Otherwise: step ← step+1.
- After reset, opcode=0x00, so the first M-cycle is a fetch from PC 0. The first opcode is latched at the end of M-cycle 0.
- Reset asserted mid-instruction aborts it on the next clk edge.
- Instruction length in M-cycles: NOP, LD r,r', INC r = 1; LD r,n, LD r,(HL), LD (HL),r, LD A,(rr), LD (HL±),A = 2; LD (HL),n = 3.

## Configuration
- CPU_CONTROL_INC_EN
  - Defined: INC r decodes as described above.
  - Undefined: INC r opcodes execute as NOP, and alu_op is always CopyA.

## Structure
- Shared package cpu_pkg holds pc_next_e, reg_sel_e, reg_op_e, alu_op_e, alu_sel_a_e, alu_sel_b_e and mem_addr_sel_e. The CPU top level and this block both import it.
- One sub-module, cpu_decoder, is natural: a purely combinational map from (opcode, step) to the control word.
- The opcode/step registers and the reset gating stay in cpu_control_unit.

## Test plan
- Reset, then 4 T-cycles with opcode 0x00 → Fetch word active, mem_addr_sel=Pc, pc_next=Inc. Opcode latched at t_cycle==3; step=0.
- Latch 0x78 (LD A,B) → one M-cycle with read1=Reg8Src, write=Reg8Dest, WriteAlu, inst_load=1.
- Latch 0x3E (LD A,n) → M0: mem_enable=1, Pc, Inc, WriteMem, inst_load=0. M1: Fetch.
- Latch 0x36 → three M-cycles. M1 has mem_write=1, addr=Hl, read1=Z. Step resets only after the M2 fetch.
- Latch 0x32 → M0: addr=Hl, mem_write=1, read1=A, reg_op=DecHl. M1: Fetch.
- Latch 0x04 with CPU_CONTROL_INC_EN defined → alu_op=IncA, WriteAlu to Reg8Dest. Without the macro → NOP word. Reset asserted mid-0x36 → default word, and the next M-cycle is a fetch.
